// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional odd/even parity, 1 or 2 stop bits.
// busy is the back-pressure signal; overrun latches any request made while a frame is in flight.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       txd,
  output logic       busy,
  output logic       tx_done,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_txd;
  logic             r_busy;
  logic             r_tx_done;
  logic             r_overrun;

  logic w_wrap;
  logic w_parity_in;

  assign w_wrap      = (r_cnt == CNT_LAST);
  // Parity is fixed at accept time so later tx_data changes cannot disturb it.
  assign w_parity_in = (PARITY == 1) ? ~^tx_data : ^tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      // Any request outside IDLE, including on the stop-completion edge, is rejected.
      if (tx_en && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (r_state != S_IDLE) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (tx_en) begin
            r_shift  <= tx_data;
            r_parity <= w_parity_in;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_txd     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              if (HAS_PARITY) begin
                r_txd   <= r_parity;
                r_state <= S_PAR;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        S_PAR: begin
          if (w_wrap) begin
            r_txd     <= 1'b1;
            r_bit_idx <= '0;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            if (r_bit_idx == STOP_LAST) begin
              r_busy    <= 1'b0;
              r_tx_done <= 1'b1;
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txd     = r_txd;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (no parity, even, odd, two stop bits) at 16 clocks/bit.
// Expected frames go into a scoreboard when driven and are compared by a frame monitor.
module tb_uart_tx_serializer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data [4];
  logic [3:0] tx_en;
  logic [3:0] txd;
  logic [3:0] busy;
  logic [3:0] tx_done;
  logic [3:0] overrun;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_en(tx_en[0]),
    .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0]), .overrun(overrun[0]));
  uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) u_pe (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_en(tx_en[1]),
    .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1]), .overrun(overrun[1]));
  uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) u_po (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_en(tx_en[2]),
    .txd(txd[2]), .busy(busy[2]), .tx_done(tx_done[2]), .overrun(overrun[2]));
  uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3]), .tx_en(tx_en[3]),
    .txd(txd[3]), .busy(busy[3]), .tx_done(tx_done[3]), .overrun(overrun[3]));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [11:0] bits;
    int         len;
  } exp_t;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par;
    int         len;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; returns at the first negedge after the accept edge.
  task automatic send(input int d, input logic [7:0] data, input logic par, input int len);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.bits = '1;
    e.bits[0] = 1'b0;
    e.bits[8:1] = data;
    if (d == 1 || d == 2) e.bits[9] = par;
    e.len = len;
    sb.push_back(e);
    tx_data[d] = data;
    tx_en[d]   = 1'b1;
    @(negedge clk);
    tx_en[d]   = 1'b0;
    tx_data[d] = ~data;
    chk("busy_after_accept", 64'(busy[d]), 64'd1);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[d] && n < 400);
    chk("wait_idle", 64'(busy[d]), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Frame monitor: captures txd while busy and compares against the scoreboard head.
  logic [191:0] cap_wave;
  logic [191:0] exp_wave;
  int           cap_len;
  bit           cap_active = 1'b0;
  int           cap_dut;
  exp_t         cur;
  logic [3:0]   busy_prev = '0;
  logic [3:0]   idle_bad  = '0;
  logic [3:0]   done_pending = '0;

  always @(negedge clk) begin
    if (reset) begin
      cap_active   = 1'b0;
      done_pending = '0;
      busy_prev    = busy;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (done_pending[d]) begin
          chk("tx_done_single", 64'(tx_done[d]), 64'd0);
          done_pending[d] = 1'b0;
        end
        if (!busy[d] && txd[d] !== 1'b1) idle_bad[d] = 1'b1;
        if (busy[d] && !busy_prev[d]) begin
          chk("idle_high", 64'(idle_bad[d]), 64'd0);
          idle_bad[d] = 1'b0;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: dut=%0d started a frame, expected none", d);
          end else begin
            cur = sb.pop_front();
            chk("frame_dut", 64'(d), 64'(cur.dut));
            cap_active = 1'b1;
            cap_dut    = d;
            cap_len    = 0;
            cap_wave   = '0;
          end
        end
        if (cap_active && cap_dut == d) begin
          if (busy[d]) begin
            if (cap_len < 192) cap_wave[cap_len] = txd[d];
            cap_len++;
          end else begin
            exp_wave = '0;
            for (int k = 0; k < cur.len && k < 192; k++) exp_wave[k] = cur.bits[k / CPB];
            chk("busy_len", 64'(cap_len), 64'(cur.len));
            n_checks++;
            if (cap_wave !== exp_wave) begin
              n_fail++;
              $display("FAIL frame_wave dut=%0d: got %h expected %h", d, cap_wave, exp_wave);
            end
            chk("tx_done_pulse", 64'(tx_done[d]), 64'd1);
            done_pending[d] = 1'b1;
            cap_active = 1'b0;
            $display("frame dut=%0d data=%02h busy_cycles=%0d", d, cur.data, cap_len);
          end
        end
      end
      busy_prev = busy;
    end
  end

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 8'h35, 1'b0, 160};
    tbl[1]  = '{1, 8'h35, 1'b0, 176};
    tbl[2]  = '{2, 8'h35, 1'b1, 176};
    tbl[3]  = '{3, 8'hFF, 1'b0, 176};
    tbl[4]  = '{0, 8'h00, 1'b0, 160};
    tbl[5]  = '{1, 8'h07, 1'b1, 176};
    tbl[6]  = '{2, 8'h07, 1'b0, 176};
    tbl[7]  = '{1, 8'hFF, 1'b0, 176};
    tbl[8]  = '{2, 8'h00, 1'b1, 176};
    tbl[9]  = '{3, 8'h5A, 1'b0, 176};
    tbl[10] = '{0, 8'h80, 1'b0, 160};

    reset = 1'b1;
    tx_en = '0;
    for (int d = 0; d < 4; d++) tx_data[d] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_txd", 64'(txd), 64'hF);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_tx_done", 64'(tx_done), 64'h0);
    chk("reset_overrun", 64'(overrun), 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_txd", 64'(txd), 64'hF);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].dut, tbl[i].data, tbl[i].par, tbl[i].len);
      wait_idle(tbl[i].dut);
      repeat (3) @(negedge clk);
    end
    chk("overrun_after_table", 64'(overrun), 64'h0);

    // Request 50 cycles into a frame is dropped and flags overrun.
    send(0, 8'h2D, 1'b0, 160);
    repeat (49) @(negedge clk);
    tx_data[0] = 8'h31;
    tx_en[0]   = 1'b1;
    @(negedge clk);
    tx_en[0]   = 1'b0;
    chk("overrun_set", 64'(overrun[0]), 64'd1);
    wait_idle(0);
    repeat (20) @(negedge clk);
    chk("overrun_sticky", 64'(overrun[0]), 64'd1);
    pulse_reset();
    chk("overrun_cleared", 64'(overrun[0]), 64'd0);

    // "-12" issued on the first cycle busy reads 0.
    send(0, 8'h2D, 1'b0, 160);
    wait_idle(0);
    send(0, 8'h31, 1'b0, 160);
    wait_idle(0);
    send(0, 8'h32, 1'b0, 160);
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("string_overrun", 64'(overrun[0]), 64'd0);

    // Request coincident with the stop-completion edge is rejected.
    send(0, 8'h55, 1'b0, 160);
    repeat (159) @(negedge clk);
    chk("busy_last_cycle", 64'(busy[0]), 64'd1);
    tx_data[0] = 8'h99;
    tx_en[0]   = 1'b1;
    @(negedge clk);
    tx_en[0]   = 1'b0;
    chk("busy_after_stop", 64'(busy[0]), 64'd0);
    chk("overrun_at_stop_edge", 64'(overrun[0]), 64'd1);
    repeat (20) @(negedge clk);
    chk("no_frame_after_stop_edge", 64'(busy[0]), 64'd0);
    pulse_reset();

    // Asynchronous reset during data bit 4 aborts the frame.
    send(0, 8'hC3, 1'b0, 160);
    repeat (84) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_txd", 64'(txd[0]), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_resume_busy", 64'(busy[0]), 64'd0);
    chk("no_resume_txd", 64'(txd[0]), 64'd1);
    send(0, 8'hA5, 1'b0, 160);
    wait_idle(0);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("final_idle_txd", 64'(txd), 64'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
